id_stage_hz: RTL
================

Name: id_stage_hz

Overview:
Parametrised instruction-decode stage for the 5-stage pipeline: register file with write-through bypass, immediate extension, load-use hazard detection, and an ID/EX pipeline register with valid bit, bubble and flush support. It sits between the IF/ID register and EX, takes pre-decoded fields and a control vector from the main control, and drives o_stall back to the PC/IF/ID stage. It generalises the current decode stage in data width, register count and control width, and adds internal hazard detection, a valid bit, bypass, and zero-extension mode.

Parameters:
XLEN, 32, datapath/PC width
NREG, 32, register-file entries; AW = $clog2(NREG); register 0 reads as zero
IMM_W, 16, raw immediate width (IMM_W < XLEN)
CTRL_W, 9, control-vector width passed to EX/MEM/WB
MEMREAD_BIT, 5, index of MemRead within the control vector

Ports:
i_clk  in  1  clock, all state on rising edge
i_rst_n  in  1  reset, synchronous, active-low
i_valid  in  1  IF/ID holds a real instruction
i_pc  in  XLEN  next-PC of the instruction
i_rs, i_rt, i_rd  in  AW each  source, target and destination register indices
i_imm  in  IMM_W  raw immediate
i_imm_zext  in  1  1 = zero-extend, 0 = sign-extend
i_ctrl  in  CTRL_W  control vector from main control
i_flush  in  1  branch/jump flush of the instruction in ID
i_reg_write, i_write_reg (AW), i_write_data (XLEN)  in  WB write port
o_valid  out  1  ID/EX holds a real instruction
o_pc, o_read_data1, o_read_data2, o_imm  out  XLEN each  registered ID/EX fields
o_sor_reg, o_tar_reg, o_des_reg  out  AW each  registered rs, rt, rd
o_ctrl  out  CTRL_W  registered control vector
o_stall  out  1  combinational; hold PC and IF/ID this cycle

Behaviour:
- Reset: when i_rst_n=0 at a clock edge, every RF entry and every ID/EX output clears to 0, including o_valid=0 and o_ctrl=0. o_stall is then 0 because o_valid=0. Reset mid-stall or mid-flush takes priority over both.
- RF write: at the clock edge when i_reg_write=1 and i_write_reg!=0, the entry is written. Writes to index 0 are ignored.
- RF read is combinational. Index 0 returns 0. If i_reg_write=1, i_write_reg==index and index!=0, the read returns i_write_data (same-cycle bypass).
- Immediate: o_imm is the registered extension of i_imm to XLEN. Sign-extend from bit IMM_W-1 when i_imm_zext=0; zero-fill when i_imm_zext=1.
- Hazard: o_stall = i_valid & o_valid & o_ctrl[MEMREAD_BIT] & (o_tar_reg!=0) & (o_tar_reg==i_rs | o_tar_reg==i_rt). Both sources are always compared; conservative stalls are accepted.
- ID/EX update each cycle, priority order: reset > bubble > load.
  - bubble when i_flush | o_stall | !i_valid: o_valid<=0 and o_ctrl<=0. Data fields load normally; they are don't-care but must be deterministic.
  - load otherwise: o_valid<=1 and all fields capture the current ID values.
- Latency is one cycle from ID inputs to the ID/EX outputs.
- A stall lasts exactly one cycle: the bubble clears o_valid, which deasserts o_stall on the next cycle.
- Flush and stall together: bubble; o_stall is still asserted that cycle.
- Register wrap: indices are exactly AW bits. NREG need not be a power of two; indices >= NREG read 0 and their writes are ignored.

Decomposition:
- Package id_pkg holds:
  - control-bit index constants: REGDST, ALUOP0, ALUOP1, ALUSRC, BRANCH, MEMREAD=5, MEMWRITE, REGWRITE, MEMTOREG
  - the default widths
  - a BUBBLE_CTRL = '0 constant
- One sub-module, regfile_bypass (parameters XLEN, NREG): two read ports, one write port with bypass, synchronous reset.
- Hazard logic, extension and the pipeline register live in id_stage_hz.

Test Plan:
- Reset, then write r5=0x0000_00AA via WB. Next cycle rs=5 -> o_read_data1=0xAA after one edge; rs=0 -> 0.
- Same-cycle WB write r7=0x1234 while ID reads rt=7 -> o_read_data2=0x1234 next edge, with no stale value.
- i_imm=0x8001: i_imm_zext=0 -> o_imm=0xFFFF_8001; i_imm_zext=1 -> o_imm=0x0000_8001.
- Load-use: lw with rt=3 and ctrl[5]=1 latched into ID/EX, then add with rs=3 in ID. Expect o_stall=1 for one cycle, then o_valid=0 and o_ctrl=0, then add loads with o_valid=1. Repeat with rt=0 as the load target -> no stall.
- i_flush=1 with a valid instruction -> next edge o_valid=0 and o_ctrl=0. Flush coincident with a stall -> single bubble, o_stall=1 that cycle only.
- Assert i_rst_n=0 for one edge mid-stream -> all outputs 0, RF reads 0. Re-run with XLEN=64, NREG=16 and check extension and bypass.

Source files
------------

// File: rtl/id_pkg.sv
// Shared constants for the decode stage: control-vector bit positions,
// default widths and the control value inserted for a pipeline bubble.
package id_pkg;

    // Default datapath geometry
    localparam int XLEN_DEF   = 32;
    localparam int NREG_DEF   = 32;
    localparam int IMM_W_DEF  = 16;
    localparam int CTRL_W_DEF = 9;

    // Bit positions inside the control vector produced by main control
    localparam int REGDST   = 0;
    localparam int ALUOP0   = 1;
    localparam int ALUOP1   = 2;
    localparam int ALUSRC   = 3;
    localparam int BRANCH   = 4;
    localparam int MEMREAD  = 5;
    localparam int MEMWRITE = 6;
    localparam int REGWRITE = 7;
    localparam int MEMTOREG = 8;

    // Control vector of a bubble: no side effects anywhere downstream
    localparam logic [CTRL_W_DEF-1:0] BUBBLE_CTRL = '0;

    // What the ID/EX register does on the next edge
    typedef enum logic [0:0] {
        IDEX_BUBBLE = 1'b0,
        IDEX_LOAD   = 1'b1
    } idex_op_e;

endpackage

// File: rtl/regfile_bypass.sv
// Register file with two combinational read ports, one write port and a
// same-cycle write-to-read bypass. Entry 0 and indices >= NREG read as zero.
module regfile_bypass #(
    parameter  int XLEN = 32,
    parameter  int NREG = 32,
    localparam int AW   = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_we,
    input  logic [AW-1:0]   i_waddr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [AW-1:0]   i_raddr1,
    input  logic [AW-1:0]   i_raddr2,
    output logic [XLEN-1:0] o_rdata1,
    output logic [XLEN-1:0] o_rdata2
);

    localparam logic [AW:0] NREG_W = (AW+1)'(NREG);

    logic [XLEN-1:0] mem_q [NREG];
    logic [XLEN-1:0] mem_d [NREG];

    logic            ok1_s, ok2_s, okw_s;
    logic            hit1_s, hit2_s;
    logic [XLEN-1:0] raw1_s, raw2_s;

    // Index 0 and out-of-range indices never hold data
    assign ok1_s = (i_raddr1 != {AW{1'b0}}) && ({1'b0, i_raddr1} < NREG_W);
    assign ok2_s = (i_raddr2 != {AW{1'b0}}) && ({1'b0, i_raddr2} < NREG_W);
    assign okw_s = (i_waddr  != {AW{1'b0}}) && ({1'b0, i_waddr}  < NREG_W);

    assign hit1_s = i_we && okw_s && (i_waddr == i_raddr1);
    assign hit2_s = i_we && okw_s && (i_waddr == i_raddr2);

    // Next-state of the array: only the addressed, legal entry changes
    always_comb begin
        mem_d[0] = '0;
        for (int i = 1; i < NREG; i++) begin
            mem_d[i] = (i_we && (i_waddr == AW'(i))) ? i_wdata : mem_q[i];
        end
    end

    // Storage update with synchronous clear
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Read port 1: bypass the in-flight write, otherwise the stored value
    always_comb begin
        raw1_s = '0;
        if (ok1_s) begin
            raw1_s = mem_q[i_raddr1];
        end else begin
            raw1_s = '0;
        end
        if (hit1_s) begin
            o_rdata1 = i_wdata;
        end else begin
            o_rdata1 = raw1_s;
        end
    end

    // Read port 2: same structure as port 1
    always_comb begin
        raw2_s = '0;
        if (ok2_s) begin
            raw2_s = mem_q[i_raddr2];
        end else begin
            raw2_s = '0;
        end
        if (hit2_s) begin
            o_rdata2 = i_wdata;
        end else begin
            o_rdata2 = raw2_s;
        end
    end

endmodule

// File: rtl/id_stage_hz.sv
// Instruction-decode stage: register read with bypass, immediate
// extension, load-use hazard detection and the ID/EX pipeline register.
module id_stage_hz
    import id_pkg::*;
#(
    parameter  int XLEN        = XLEN_DEF,
    parameter  int NREG        = NREG_DEF,
    parameter  int IMM_W       = IMM_W_DEF,
    parameter  int CTRL_W      = CTRL_W_DEF,
    parameter  int MEMREAD_BIT = MEMREAD,
    localparam int AW          = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic [XLEN-1:0]   i_pc,
    input  logic [AW-1:0]     i_rs,
    input  logic [AW-1:0]     i_rt,
    input  logic [AW-1:0]     i_rd,
    input  logic [IMM_W-1:0]  i_imm,
    input  logic              i_imm_zext,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic              i_flush,
    input  logic              i_reg_write,
    input  logic [AW-1:0]     i_write_reg,
    input  logic [XLEN-1:0]   i_write_data,
    output logic              o_valid,
    output logic [XLEN-1:0]   o_pc,
    output logic [XLEN-1:0]   o_read_data1,
    output logic [XLEN-1:0]   o_read_data2,
    output logic [XLEN-1:0]   o_imm,
    output logic [AW-1:0]     o_sor_reg,
    output logic [AW-1:0]     o_tar_reg,
    output logic [AW-1:0]     o_des_reg,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic              o_stall
);

    // ID/EX register state and its next-state
    logic              valid_q, valid_d;
    logic [XLEN-1:0]   pc_q,    pc_d;
    logic [XLEN-1:0]   rd1_q,   rd1_d;
    logic [XLEN-1:0]   rd2_q,   rd2_d;
    logic [XLEN-1:0]   imm_q,   imm_d;
    logic [AW-1:0]     sor_q,   sor_d;
    logic [AW-1:0]     tar_q,   tar_d;
    logic [AW-1:0]     des_q,   des_d;
    logic [CTRL_W-1:0] ctrl_q,  ctrl_d;

    logic [XLEN-1:0]   rdata1_s, rdata2_s;
    logic [XLEN-1:0]   imm_ext_s;
    logic              stall_s;
    idex_op_e          op_s;

    regfile_bypass #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_rf (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_we     (i_reg_write),
        .i_waddr  (i_write_reg),
        .i_wdata  (i_write_data),
        .i_raddr1 (i_rs),
        .i_raddr2 (i_rt),
        .o_rdata1 (rdata1_s),
        .o_rdata2 (rdata2_s)
    );

    // Load in EX whose target feeds either source of the instruction in ID.
    // Both sources are compared even if the instruction only uses one.
    always_comb begin
        stall_s = 1'b0;
        if (i_valid && valid_q && ctrl_q[MEMREAD_BIT] && (tar_q != {AW{1'b0}}) &&
            ((tar_q == i_rs) || (tar_q == i_rt))) begin
            stall_s = 1'b1;
        end else begin
            stall_s = 1'b0;
        end
    end

    // Sign- or zero-extend the raw immediate to the datapath width
    always_comb begin
        imm_ext_s = '0;
        if (i_imm_zext) begin
            imm_ext_s = {{(XLEN-IMM_W){1'b0}}, i_imm};
        end else begin
            imm_ext_s = {{(XLEN-IMM_W){i_imm[IMM_W-1]}}, i_imm};
        end
    end

    // ID/EX next-state: a bubble kills valid and control, data still loads
    always_comb begin
        op_s    = IDEX_LOAD;
        valid_d = 1'b0;
        ctrl_d  = '0;
        pc_d    = i_pc;
        rd1_d   = rdata1_s;
        rd2_d   = rdata2_s;
        imm_d   = imm_ext_s;
        sor_d   = i_rs;
        tar_d   = i_rt;
        des_d   = i_rd;
        if (i_flush || stall_s || !i_valid) begin
            op_s = IDEX_BUBBLE;
        end else begin
            op_s = IDEX_LOAD;
        end
        case (op_s)
            IDEX_LOAD: begin
                valid_d = 1'b1;
                ctrl_d  = i_ctrl;
            end
            IDEX_BUBBLE: begin
                valid_d = 1'b0;
                ctrl_d  = CTRL_W'(BUBBLE_CTRL);
            end
            default: begin
                valid_d = 1'b0;
                ctrl_d  = CTRL_W'(BUBBLE_CTRL);
            end
        endcase
    end

    // ID/EX register with synchronous clear
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            sor_q   <= '0;
            tar_q   <= '0;
            des_q   <= '0;
            ctrl_q  <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            imm_q   <= imm_d;
            sor_q   <= sor_d;
            tar_q   <= tar_d;
            des_q   <= des_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign o_valid      = valid_q;
    assign o_pc         = pc_q;
    assign o_read_data1 = rd1_q;
    assign o_read_data2 = rd2_q;
    assign o_imm        = imm_q;
    assign o_sor_reg    = sor_q;
    assign o_tar_reg    = tar_q;
    assign o_des_reg    = des_q;
    assign o_ctrl       = ctrl_q;
    assign o_stall      = stall_s;

endmodule
